// File: rtl/clock_divider_pkg.sv
// Shared constants and types for the clock divider bank.
package clock_divider_pkg;

  localparam int CLK_EDGE_CNT_W = 16;
  localparam int MIN_DIV        = 2;
  localparam int CLKDIV_DIV_W   = 8;

  // Snapshot of one channel's control state at the default ratio width.
  typedef struct packed {
    logic [CLKDIV_DIV_W-1:0] cnt;
    logic [CLKDIV_DIV_W-1:0] div;
    logic [CLKDIV_DIV_W-1:0] shadow;
    logic                    pending;
    logic                    running;
  } clkdiv_chan_state_t;

endpackage

// File: rtl/clock_divider_channel.sv
// One divided-clock channel: period counter, waveform, staged ratio load and
// optional rising-edge counter (CLOCK_DIVIDER_BANK_EDGE_COUNT_EN).
module clock_divider_channel
  import clock_divider_pkg::*;
#(
  parameter int DIV_WIDTH   = 8,
  parameter int DEFAULT_DIV = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      wr_en,
  input  logic [DIV_WIDTH-1:0]      wr_ratio,
  output logic                      pending,
  output logic                      running,
  output logic                      clk_out,
  output logic                      rise_pulse,
  output logic [CLK_EDGE_CNT_W-1:0] edge_count
);

  localparam logic [DIV_WIDTH-1:0] DIV_RST = DIV_WIDTH'(DEFAULT_DIV);
  localparam logic [DIV_WIDTH-1:0] DIV_MIN = DIV_WIDTH'(MIN_DIV);

  // Ratios below the minimum cannot form a high and a low phase.
  function automatic logic [DIV_WIDTH-1:0] clamp_div(input logic [DIV_WIDTH-1:0] r);
    return (r < DIV_MIN) ? DIV_MIN : r;
  endfunction

  logic [DIV_WIDTH-1:0] cnt;
  logic [DIV_WIDTH-1:0] div;
  logic [DIV_WIDTH-1:0] shadow;
  logic [DIV_WIDTH-1:0] cnt_inc;
  logic                 boundary;
  logic                 load;

  assign cnt_inc  = cnt + DIV_WIDTH'(1);
  assign boundary = running & (cnt == (div - DIV_WIDTH'(1)));
  // A staged ratio takes over only between periods, so no pulse is truncated.
  assign load     = pending & (~running | boundary);

  // Period counter, waveform and ratio handover; en is only honoured between periods.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt        <= '0;
      div        <= DIV_RST;
      pending    <= 1'b0;
      running    <= 1'b0;
      clk_out    <= 1'b0;
      rise_pulse <= 1'b0;
    end else begin
      if (load) begin
        div     <= clamp_div(shadow);
        pending <= 1'b0;
      end else if (wr_en) begin
        pending <= 1'b1;
      end
      if (!running || boundary) begin
        cnt        <= '0;
        running    <= en;
        clk_out    <= en;
        rise_pulse <= en;
      end else begin
        cnt        <= cnt_inc;
        clk_out    <= (cnt_inc < (div >> 1));
        rise_pulse <= 1'b0;
      end
    end
  end

  // Staged ratio; meaningless unless pending is set, so it needs no reset.
  always_ff @(posedge clock) begin
    if (wr_en) shadow <= wr_ratio;
  end

`ifdef CLOCK_DIVIDER_BANK_EDGE_COUNT_EN
  // Free-running count of rising edges, wrapping at full scale.
  always_ff @(posedge clock) begin
    if (reset)           edge_count <= '0;
    else if (rise_pulse) edge_count <= edge_count + CLK_EDGE_CNT_W'(1);
  end
`else
  assign edge_count = '0;
`endif

endmodule

// File: rtl/clock_divider_bank.sv
// Multi-channel programmable clock divider with valid/ready ratio updates.
// Optional per-channel edge counters: define CLOCK_DIVIDER_BANK_EDGE_COUNT_EN.
module clock_divider_bank
  import clock_divider_pkg::*;
#(
  parameter int  NUM_CHANNELS = 4,
  parameter int  DIV_WIDTH    = 8,
  parameter int  DEFAULT_DIV  = 4,
  localparam int CHAN_W       = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1
) (
  input  logic                                   clock,
  input  logic                                   reset,
  input  logic [NUM_CHANNELS-1:0]                power,
  input  logic [NUM_CHANNELS-1:0]                gate,
  input  logic                                   div_valid,
  output logic                                   div_ready,
  input  logic [CHAN_W-1:0]                      div_chan,
  input  logic [DIV_WIDTH-1:0]                   div_ratio,
  output logic [NUM_CHANNELS-1:0]                clk_out,
  output logic [NUM_CHANNELS-1:0]                rise_pulse,
  output logic [NUM_CHANNELS-1:0]                running,
  output logic [NUM_CHANNELS*CLK_EDGE_CNT_W-1:0] edge_count
);

  localparam int PAD_N = 1 << CHAN_W;

  logic [NUM_CHANNELS-1:0] en;
  logic [NUM_CHANNELS-1:0] pending;
  logic [NUM_CHANNELS-1:0] wr_sel;
  logic [PAD_N-1:0]        pending_ext;
  logic                    chan_ok;
  logic                    accept;

  assign en      = power & ~gate;
  // Addresses beyond the last channel are never accepted.
  assign chan_ok = ({1'b0, div_chan} < (CHAN_W + 1)'(NUM_CHANNELS));

  // Widen pending so every div_chan code indexes a defined bit.
  always_comb begin
    pending_ext                   = '0;
    pending_ext[NUM_CHANNELS-1:0] = pending;
  end

  assign div_ready = ~reset & chan_ok & ~pending_ext[div_chan];
  assign accept    = div_valid & div_ready;

  for (genvar i = 0; i < NUM_CHANNELS; i++) begin : g_chan
    assign wr_sel[i] = accept & (div_chan == CHAN_W'(i));

    clock_divider_channel #(
      .DIV_WIDTH   (DIV_WIDTH),
      .DEFAULT_DIV (DEFAULT_DIV)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .en         (en[i]),
      .wr_en      (wr_sel[i]),
      .wr_ratio   (div_ratio),
      .pending    (pending[i]),
      .running    (running[i]),
      .clk_out    (clk_out[i]),
      .rise_pulse (rise_pulse[i]),
      .edge_count (edge_count[i*CLK_EDGE_CNT_W +: CLK_EDGE_CNT_W])
    );
  end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Scoreboard bench for clock_divider_bank: stimulus queues cycle-tagged
// expectations, a negedge monitor compares them against the outputs.
module tb_clock_divider_bank;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  power = 4'h0;
  logic [3:0]  gate = 4'h0;
  logic        div_valid = 1'b0;
  logic        div_ready;
  logic [1:0]  div_chan = 2'd0;
  logic [7:0]  div_ratio = 8'd0;
  logic [3:0]  clk_out;
  logic [3:0]  rise_pulse;
  logic [3:0]  running;
  logic [63:0] edge_count;

  clock_divider_bank #(
    .NUM_CHANNELS (4),
    .DIV_WIDTH    (8),
    .DEFAULT_DIV  (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .power      (power),
    .gate       (gate),
    .div_valid  (div_valid),
    .div_ready  (div_ready),
    .div_chan   (div_chan),
    .div_ratio  (div_ratio),
    .clk_out    (clk_out),
    .rise_pulse (rise_pulse),
    .running    (running),
    .edge_count (edge_count)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // kind 0: {clk_out, rise_pulse, running}; kind 1: div_ready; kind 2: edge_count
  typedef struct {
    int          cyc;
    int          kind;
    int          ch;
    logic [15:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic push(input int c, input int kind, input int ch, input logic [15:0] v);
    exp_t e;
    e.cyc  = c;
    e.kind = kind;
    e.ch   = ch;
    e.val  = v;
    sb.push_back(e);
  endtask

  // Pattern bits are listed MSB first; a period always starts with its rising edge.
  task automatic push_pat(input int ch, input int start, input logic [7:0] pat,
                          input int len, input int reps);
    for (int r = 0; r < reps; r++)
      for (int k = 0; k < len; k++)
        push(start + r * len + k, 0, ch, {13'b0, pat[len-1-k], (k == 0), 1'b1});
  endtask

  task automatic push_idle(input int ch, input int start, input int n);
    for (int k = 0; k < n; k++) push(start + k, 0, ch, 16'h0000);
  endtask

  task automatic push_ready(input int c, input logic v);
    push(c, 1, 0, {15'b0, v});
  endtask

  task automatic do_check(input exp_t e);
    logic [15:0] act;
    string       name;
    case (e.kind)
      0:       begin act = {13'b0, clk_out[e.ch], rise_pulse[e.ch], running[e.ch]}; name = "clk/rise/run"; end
      1:       begin act = {15'b0, div_ready}; name = "div_ready"; end
      default: begin act = edge_count[e.ch*16 +: 16]; name = "edge_count"; end
    endcase
    n_checks++;
    if (e.cyc != cyc)
      $display("FAIL %s ch%0d: expectation for cyc %0d reached only at cyc %0d (got %h required %h)",
               name, e.ch, e.cyc, cyc, act, e.val);
    else if (act === e.val)
      n_pass++;
    else
      $display("FAIL %s ch%0d cyc %0d: got %h required %h", name, e.ch, cyc, act, e.val);
  endtask

  // Monitor: retire every expectation due in the current cycle.
  always @(negedge clock) begin
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc <= cyc) begin
        do_check(sb[i]);
        sb.delete(i);
      end
    end
  end

  task automatic wait_cyc(input int n);
    while (cyc < n) begin
      @(posedge clock);
      #1;
    end
  endtask

  int exp_edges[4];

  initial begin
`ifdef CLOCK_DIVIDER_BANK_EDGE_COUNT_EN
    exp_edges = '{13, 15, 10, 15};
`else
    exp_edges = '{0, 0, 0, 0};
`endif
    // Reset state
    for (int ch = 0; ch < 4; ch++) begin
      push_idle(ch, 3, 1);
      push(3, 2, ch, 16'h0000);
    end
    push_ready(3, 1'b0);

    // Release: every channel starts at D=4 one cycle later
    wait_cyc(4);
    reset = 1'b0;
    power = 4'hF;
    gate  = 4'h0;
    push_ready(4, 1'b1);
    push_pat(0, 5, 8'b1100, 4, 8);
    push_pat(0, 37, 8'b111000, 6, 1);
    push_pat(0, 43, 8'b10, 2, 4);
    push_pat(1, 5, 8'b1100, 4, 2);
    push_pat(1, 13, 8'b100, 3, 12);
    push_pat(2, 5, 8'b1100, 4, 5);
    push_idle(2, 25, 6);
    push_pat(2, 31, 8'b1100, 4, 5);
    push_pat(3, 5, 8'b1100, 4, 3);
    push_idle(3, 17, 10);
    push_pat(3, 27, 8'b10, 2, 12);

    // ch1 -> 3 mid-period; loads at the boundary closing cycle 12
    wait_cyc(10);
    div_valid = 1'b1; div_chan = 2'd1; div_ratio = 8'd3;
    push_ready(10, 1'b1);
    wait_cyc(11);
    div_valid = 1'b0;
    push_ready(11, 1'b0);
    push_ready(12, 1'b0);
    push_ready(13, 1'b1);

    // ch3 powered down mid-period; stops after its boundary
    wait_cyc(14);
    power[3] = 1'b0;

    // ratios 0 then 1 to idle ch3, each loading one cycle after accept
    wait_cyc(18);
    div_valid = 1'b1; div_chan = 2'd3; div_ratio = 8'd0;
    push_ready(18, 1'b1);
    wait_cyc(19);
    div_valid = 1'b0;
    push_ready(19, 1'b0);
    wait_cyc(20);
    div_valid = 1'b1; div_ratio = 8'd1;
    push_ready(20, 1'b1);
    wait_cyc(21);
    div_valid = 1'b0;
    push_ready(21, 1'b0);
    push_ready(22, 1'b1);

    // gate ch2 at cnt=1; period completes, then idle
    wait_cyc(22);
    gate[2] = 1'b1;
    wait_cyc(26);
    power[3] = 1'b1;
    wait_cyc(30);
    gate[2] = 1'b0;

    // ch0: ratio 6, then a second write held while pending
    wait_cyc(34);
    div_valid = 1'b1; div_chan = 2'd0; div_ratio = 8'd6;
    push_ready(34, 1'b1);
    wait_cyc(35);
    div_ratio = 8'd2;
    push_ready(35, 1'b0);
    push_ready(36, 1'b0);
    push_ready(37, 1'b1);
    wait_cyc(38);
    div_valid = 1'b0;
    push_ready(38, 1'b0);
    push_ready(42, 1'b0);
    push_ready(43, 1'b1);

    // edge counters, then reset in mid-period
    wait_cyc(51);
    for (int ch = 0; ch < 4; ch++) push(51, 2, ch, 16'(exp_edges[ch]));
    reset = 1'b1;
    for (int ch = 0; ch < 4; ch++) begin
      push_idle(ch, 52, 1);
      push(52, 2, ch, 16'h0000);
    end
    push_ready(52, 1'b0);

    // after reset every channel is back at DEFAULT_DIV
    wait_cyc(53);
    reset = 1'b0;
    push_ready(53, 1'b1);
    for (int ch = 0; ch < 4; ch++) push_pat(ch, 54, 8'b1100, 4, 2);

    wait_cyc(64);
    for (int i = 0; i < sb.size(); i++) begin
      n_checks++;
      $display("FAIL unchecked kind%0d ch%0d cyc %0d: never compared, required %h",
               sb[i].kind, sb[i].ch, sb[i].cyc, sb[i].val);
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL watchdog: run did not finish, %0d/%0d checks passed so far", n_pass, n_checks);
    $fatal(1);
  end

endmodule
